swd_req_parser: RTL and testbench

//  Consumes the per-edge SWDIO bit stream sampled by swd_frontend_top (sck domain) and tracks
//  SWD link state: line reset (>=RESET_LEN ones), idle (zeros), and the 8-bit request header.

---
 rtl/swd_req_parser_pkg.sv | 33 +++
 rtl/swd_req_parser_if.sv | 32 +++
 rtl/swd_req_parser.sv | 133 +++++++++++++
 tb/tb_swd_req_parser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/swd_req_parser_pkg.sv
// Shared definitions for the SWD request parser and the downstream
// ACK/data-phase engine.
//   link_state_e : FSM state encodings (also exported on link_state)
//   HDR_*        : bit positions within the 8-bit LSB-first request header
//   hdr_good()   : well-formedness check of a complete header
package swd_req_parser_pkg;

    typedef enum logic [2:0] {
        ST_UNSYNC     = 3'd0,
        ST_RESET_SEEN = 3'd1,
        ST_IDLE       = 3'd2,
        ST_HDR        = 3'd3,
        ST_BUSY       = 3'd4
    } link_state_e;

    localparam int unsigned HDR_START  = 0;
    localparam int unsigned HDR_APNDP  = 1;
    localparam int unsigned HDR_RNW    = 2;
    localparam int unsigned HDR_A_LO   = 3;
    localparam int unsigned HDR_A_HI   = 4;
    localparam int unsigned HDR_PARITY = 5;
    localparam int unsigned HDR_STOP   = 6;
    localparam int unsigned HDR_PARK   = 7;

    // Even parity over APnDP, RnW, A[3:2]; stop must be 0, park must be 1.
    function automatic logic hdr_good(input logic [7:0] h);
        return h[HDR_START]
             & ((^h[HDR_A_HI:HDR_APNDP]) == h[HDR_PARITY])
             & ~h[HDR_STOP]
             & h[HDR_PARK];
    endfunction

endpackage

// File: rtl/swd_req_parser_if.sv
// Bit-stream / request bundle between the SWD frontend, the request parser
// and the ACK/data-phase engine.
//   master : frontend/engine side - drives bit_valid, bit_in, phase_done,
//            observes the parser's events, decoded fields and debug state
//   slave  : parser side
interface swd_req_parser_if #(
    parameter int unsigned IDLE_W = 8
) ();
    logic              bit_valid;
    logic              bit_in;
    logic              phase_done;
    logic              line_reset;
    logic              req_valid;
    logic              req_err;
    logic              req_apndp;
    logic              req_rnw;
    logic [1:0]        req_addr;
    logic [IDLE_W-1:0] idle_cnt;
    logic [2:0]        link_state;

    modport master (
        output bit_valid, bit_in, phase_done,
        input  line_reset, req_valid, req_err, req_apndp, req_rnw,
               req_addr, idle_cnt, link_state
    );

    modport slave (
        input  bit_valid, bit_in, phase_done,
        output line_reset, req_valid, req_err, req_apndp, req_rnw,
               req_addr, idle_cnt, link_state
    );
endinterface

// File: rtl/swd_req_parser.sv
// SWD link-state tracker and request-header parser (sck domain).
// Detects line reset (RESET_LEN consecutive ones), counts idle zeros and
// decodes the 8-bit request header, handing off to the ACK/data engine
// until it signals phase_done.
//   sck, rst_n : clock, synchronous active-low reset
//   bus        : slave side of swd_req_parser_if (bit stream in, event
//                pulses, held request fields, idle_cnt, link_state out)
module swd_req_parser
    import swd_req_parser_pkg::*;
#(
    parameter int unsigned RESET_LEN = 50,
    parameter int unsigned IDLE_W    = 8
) (
    input  logic            sck,
    input  logic            rst_n,
    swd_req_parser_if.slave bus
);

    localparam int unsigned       ONES_W    = $clog2(RESET_LEN + 1);
    localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(RESET_LEN);
    localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(RESET_LEN - 1);

    link_state_e       state;
    logic [ONES_W-1:0] ones_cnt;
    logic [6:0]        hdr_sr;
    logic [2:0]        bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              line_reset_q;
    logic              req_valid_q;
    logic              req_err_q;
    logic              apndp_q;
    logic              rnw_q;
    logic [1:0]        addr_q;

    logic              reset_hit;
    logic [7:0]        hdr_full;

    always_comb begin
        reset_hit = bus.bit_valid && bus.bit_in && (ones_cnt == ONES_LAST);
        // Earlier bits enter at the top and shift down, so after seven bits
        // the start bit sits at hdr_sr[0] and the incoming bit is the park bit.
        hdr_full  = {bus.bit_in, hdr_sr};
    end

    always_ff @(posedge sck) begin
        if (!rst_n) begin
            state        <= ST_UNSYNC;
            ones_cnt     <= '0;
            hdr_sr       <= '0;
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            line_reset_q <= 1'b0;
            req_valid_q  <= 1'b0;
            req_err_q    <= 1'b0;
            apndp_q      <= 1'b0;
            rnw_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            line_reset_q <= 1'b0;
            req_valid_q  <= 1'b0;
            req_err_q    <= 1'b0;

            if (bus.bit_valid) begin
                if (!bus.bit_in) begin
                    ones_cnt <= '0;
                end else if (ones_cnt != ONES_MAX) begin
                    ones_cnt <= ones_cnt + ONES_W'(1);
                end

                // Line reset overrides every state, including a header in flight.
                if (reset_hit) begin
                    line_reset_q <= 1'b1;
                    state        <= ST_RESET_SEEN;
                    bit_cnt      <= '0;
                end else begin
                    unique case (state)
                        ST_UNSYNC: ;
                        ST_RESET_SEEN: begin
                            if (!bus.bit_in) begin
                                state    <= ST_IDLE;
                                idle_cnt <= IDLE_W'(1);
                            end
                        end
                        ST_IDLE: begin
                            if (bus.bit_in) begin
                                state   <= ST_HDR;
                                hdr_sr  <= 7'b100_0000;
                                bit_cnt <= 3'd1;
                            end else if (idle_cnt != '1) begin
                                idle_cnt <= idle_cnt + IDLE_W'(1);
                            end
                        end
                        ST_HDR: begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                if (hdr_good(hdr_full)) begin
                                    req_valid_q <= 1'b1;
                                    apndp_q     <= hdr_full[HDR_APNDP];
                                    rnw_q       <= hdr_full[HDR_RNW];
                                    addr_q      <= hdr_full[HDR_A_HI:HDR_A_LO];
                                    state       <= ST_BUSY;
                                end else begin
                                    req_err_q <= 1'b1;
                                    state     <= ST_UNSYNC;
                                end
                            end else begin
                                hdr_sr  <= {bus.bit_in, hdr_sr[6:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        ST_BUSY: begin
                            if (bus.phase_done) begin
                                state    <= ST_IDLE;
                                idle_cnt <= '0;
                            end
                        end
                        default: state <= ST_UNSYNC;
                    endcase
                end
            end
        end
    end

    assign bus.line_reset = line_reset_q;
    assign bus.req_valid  = req_valid_q;
    assign bus.req_err    = req_err_q;
    assign bus.req_apndp  = apndp_q;
    assign bus.req_rnw    = rnw_q;
    assign bus.req_addr   = addr_q;
    assign bus.idle_cnt   = idle_cnt;
    assign bus.link_state = state;

endmodule

// File: tb/tb_swd_req_parser.sv
// Self-checking bench for swd_req_parser: directed sequences plus a
// table of per-bit vectors with hand-computed expected outputs.
module tb_swd_req_parser;

    logic sck;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    swd_req_parser_if #(.IDLE_W(8)) bus ();

    swd_req_parser #(.RESET_LEN(50), .IDLE_W(8)) dut (
        .sck   (sck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    typedef struct {
        logic v;
        logic b;
        logic pd;
        int   st;
        int   lr;
        int   rv;
        int   re;
        int   ap;
        int   rw;
        int   ad;
        int   idle;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic pd);
        bus.bit_valid  = v;
        bus.bit_in     = b;
        bus.phase_done = pd;
        @(posedge sck);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // 50 ones from a zeroed ones counter: one pulse, on the 50th bit.
    task automatic do_line_reset(input string tag);
        int pulses = 0;
        int at     = -1;
        for (int i = 1; i <= 50; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus.line_reset) begin
                pulses++;
                at = i;
            end
        end
        chk({tag, "_lr_count"}, pulses, 1);
        chk({tag, "_lr_at"}, at, 50);
        chk({tag, "_state"}, int'(bus.link_state), 1);
    endtask

    task automatic add(input logic v, input logic b, input logic pd, input int st,
                       input int lr, input int rv, input int re, input int ap,
                       input int rw, input int ad, input int idle);
        vec_t e;
        e.v = v; e.b = b; e.pd = pd; e.st = st; e.lr = lr; e.rv = rv; e.re = re;
        e.ap = ap; e.rw = rw; e.ad = ad; e.idle = idle;
        tv.push_back(e);
    endtask

    initial begin
        int         pulses;
        int         at;
        int         rv_cnt;
        int         re_cnt;
        logic [7:0] hv;
        string      tag;

        rst_n          = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.bit_in     = 1'b0;
        bus.phase_done = 1'b0;

        // ---- reset state ----
        apply_reset();
        chk("rst_state", int'(bus.link_state), 0);
        chk("rst_lr", int'(bus.line_reset), 0);
        chk("rst_rv", int'(bus.req_valid), 0);
        chk("rst_re", int'(bus.req_err), 0);
        chk("rst_apndp", int'(bus.req_apndp), 0);
        chk("rst_rnw", int'(bus.req_rnw), 0);
        chk("rst_addr", int'(bus.req_addr), 0);
        chk("rst_idle", int'(bus.idle_cnt), 0);

        // ---- 64 ones then zeros: single line reset, idle counting, saturation ----
        do_line_reset("runA");
        pulses = 0;
        for (int i = 51; i <= 64; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus.line_reset) pulses++;
        end
        for (int i = 1; i <= 50; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.line_reset) pulses++;
            if (i == 1) begin
                chk("runA_first0_state", int'(bus.link_state), 2);
                chk("runA_first0_idle", int'(bus.idle_cnt), 1);
            end
        end
        chk("runA_extra_lr", pulses, 0);
        chk("runA_idle50", int'(bus.idle_cnt), 50);
        for (int i = 0; i < 250; i++) step(1'b1, 1'b0, 1'b0);
        chk("runA_idle_sat", int'(bus.idle_cnt), 255);
        chk("runA_idle_state", int'(bus.link_state), 2);

        // ---- 49 ones, zero, 49 ones: no line reset ----
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 99; i++) begin
            step(1'b1, (i == 49) ? 1'b0 : 1'b1, 1'b0);
            if (bus.line_reset) pulses++;
        end
        chk("runB_lr", pulses, 0);
        chk("runB_state", int'(bus.link_state), 0);

        // ---- table: idle, header A5, BUSY, header BB with gaps, bad header 85 ----
        apply_reset();
        do_line_reset("tbl");
        //  v  b  pd st lr rv re ap rw ad idle
        add(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 2);   // phase_done ignored in IDLE
        // 8'hA5 LSB-first: 1,0,1,0,0,1,0,1 (DP read, A=0)
        add(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2);
        add(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2);
        add(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2);
        add(1, 1, 0, 4, 0, 1, 0, 0, 1, 0, 2);
        add(1, 0, 0, 4, 0, 0, 0, 0, 1, 0, 2);
        add(1, 1, 0, 4, 0, 0, 0, 0, 1, 0, 2);   // bits ignored in BUSY
        add(1, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0);
        // 8'hBB LSB-first: 1,1,0,1,1,1,0,1 (AP write, A=3) with gaps
        add(1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 4, 0, 1, 0, 1, 0, 3, 0);
        add(1, 0, 1, 2, 0, 0, 0, 1, 0, 3, 0);
        add(1, 0, 0, 2, 0, 0, 0, 1, 0, 3, 1);
        add(1, 0, 0, 2, 0, 0, 0, 1, 0, 3, 2);
        add(1, 0, 0, 2, 0, 0, 0, 1, 0, 3, 3);
        // 8'h85 LSB-first: 1,0,1,0,0,0,0,1 (parity wrong)
        add(1, 1, 0, 3, 0, 0, 0, 1, 0, 3, 3);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0, 3, 3);
        add(1, 1, 0, 3, 0, 0, 0, 1, 0, 3, 3);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0, 3, 3);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0, 3, 3);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0, 3, 3);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0, 3, 3);
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 3, 3);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 3);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0, 3, 3);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].v, tv[i].b, tv[i].pd);
            tag = $sformatf("vec%0d", i);
            chk({tag, "_state"}, int'(bus.link_state), tv[i].st);
            chk({tag, "_lr"},    int'(bus.line_reset), tv[i].lr);
            chk({tag, "_rv"},    int'(bus.req_valid),  tv[i].rv);
            chk({tag, "_re"},    int'(bus.req_err),    tv[i].re);
            chk({tag, "_apndp"}, int'(bus.req_apndp),  tv[i].ap);
            chk({tag, "_rnw"},   int'(bus.req_rnw),    tv[i].rw);
            chk({tag, "_addr"},  int'(bus.req_addr),   tv[i].ad);
            chk({tag, "_idle"},  int'(bus.idle_cnt),   tv[i].idle);
        end

        // ---- line reset while BUSY; phase_done in the same cycle ----
        apply_reset();
        do_line_reset("busy");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("busy_idle10", int'(bus.idle_cnt), 10);
        hv = 8'hA5;
        for (int i = 0; i < 8; i++) step(1'b1, hv[i], 1'b0);
        chk("busy_hdr_rv", int'(bus.req_valid), 1);
        chk("busy_hdr_state", int'(bus.link_state), 4);
        // park bit already counted: the 49th further one completes the run
        pulses = 0;
        at     = -1;
        for (int i = 1; i <= 50; i++) begin
            step(1'b1, 1'b1, (i == 49) ? 1'b1 : 1'b0);
            if (bus.line_reset) begin
                pulses++;
                at = i;
            end
            if (i == 48) chk("busy_pre_state", int'(bus.link_state), 4);
            if (i == 49) chk("busy_lr_pd_state", int'(bus.link_state), 1);
        end
        chk("busy_lr_count", pulses, 1);
        chk("busy_lr_at", at, 49);
        chk("busy_end_state", int'(bus.link_state), 1);

        // ---- reset mid-header discards it ----
        apply_reset();
        do_line_reset("mid");
        step(1'b1, 1'b0, 1'b0);
        hv = 8'hA5;
        for (int i = 0; i < 3; i++) step(1'b1, hv[i], 1'b0);
        chk("mid_hdr_state", int'(bus.link_state), 3);
        rst_n = 1'b0;
        step(1'b1, hv[3], 1'b0);
        rst_n = 1'b1;
        chk("mid_rst_state", int'(bus.link_state), 0);
        chk("mid_rst_rv", int'(bus.req_valid), 0);
        chk("mid_rst_re", int'(bus.req_err), 0);
        chk("mid_rst_idle", int'(bus.idle_cnt), 0);
        rv_cnt = 0;
        re_cnt = 0;
        for (int i = 4; i < 8; i++) begin
            step(1'b1, hv[i], 1'b0);
            if (bus.req_valid) rv_cnt++;
            if (bus.req_err) re_cnt++;
        end
        chk("mid_tail_rv", rv_cnt, 0);
        chk("mid_tail_re", re_cnt, 0);
        chk("mid_tail_state", int'(bus.link_state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
